// File: rtl/game_state_ctrl.sv
// Game phase sequencer: tracks lives, level and remaining blocks, and drives the
// per-layer enables, serve-hold flag and block-map reload pulse for the display path.
module game_state_ctrl #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned NUM_BLOCKS   = 40,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned DEATH_FRAMES = 90,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       ball_lost,
  input  logic       block_hit,
  output logic       en_ball,
  output logic       en_block,
  output logic       en_paddle,
  output logic       en_back,
  output logic       ball_hold,
  output logic       level_load,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic [1:0] level
);

  localparam logic [1:0] LivesInit = 2'(LIVES);
  localparam logic [6:0] NumBlocks = 7'(NUM_BLOCKS);
  localparam logic [6:0] ServeLast = 7'(SERVE_FRAMES - 1);
  localparam logic [6:0] DeathLast = 7'(DEATH_FRAMES - 1);
  localparam logic [6:0] BlinkLast = 7'(BLINK_FRAMES - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StServe = 3'd2,
    StPlay  = 3'd3,
    StDie   = 3'd4,
    StOver  = 3'd5,
    StWin   = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic       btn_q;
  logic       start_evt;
  logic [6:0] frame_cnt_q, frame_cnt_d;
  logic [6:0] blink_cnt_q, blink_cnt_d;
  logic       blink_q, blink_d;
  logic [6:0] blocks_q, blocks_d;
  logic [1:0] lives_q, lives_d;
  logic [1:0] level_q, level_d;
  logic       new_game_q, new_game_d;
  logic       en_ball_d, en_block_d, en_paddle_d, en_back_d, ball_hold_d, level_load_d;

  assign start_evt = btn_start & ~btn_q;

  always_comb begin
    state_d    = state_q;
    new_game_d = new_game_q;
    lives_d    = lives_q;
    level_d    = level_q;
    blocks_d   = blocks_q;
    case (state_q)
      StIdle: begin
        if (start_evt) begin
          state_d    = StLoad;
          new_game_d = 1'b1;
        end
      end
      StLoad: begin
        blocks_d = NumBlocks;
        if (new_game_q) begin
          lives_d    = LivesInit;
          level_d    = 2'd0;
          new_game_d = 1'b0;
        end
        state_d = StServe;
      end
      StServe: begin
        if (start_evt || (frame_tick && (frame_cnt_q == ServeLast))) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        // Clearing the last block wins even if the ball is lost in the same cycle.
        if (block_hit && (blocks_q == 7'd1)) begin
          state_d = StWin;
        end else if (ball_lost) begin
          state_d = StDie;
        end
        if (block_hit && (blocks_q != 7'd0)) begin
          blocks_d = blocks_q - 7'd1;
        end
      end
      StDie: begin
        if (frame_tick && (frame_cnt_q == DeathLast)) begin
          lives_d = lives_q - 2'd1;
          state_d = (lives_q == 2'd1) ? StOver : StServe;
        end
      end
      StOver: begin
        if (start_evt) begin
          state_d    = StLoad;
          new_game_d = 1'b1;
        end
      end
      StWin: begin
        if (start_evt) begin
          level_d = level_q + 2'd1;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A tick on the entry edge is swallowed because entry clears the counter.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q) begin
      frame_cnt_d = 7'd0;
    end else if (frame_tick && ((state_q == StServe) || (state_q == StDie))) begin
      frame_cnt_d = frame_cnt_q + 7'd1;
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (frame_tick) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = 7'd0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 7'd1;
      end
    end
  end

  always_comb begin
    en_back_d    = 1'b1;
    en_block_d   = 1'b0;
    en_paddle_d  = 1'b0;
    en_ball_d    = 1'b0;
    ball_hold_d  = 1'b1;
    level_load_d = 1'b0;
    case (state_d)
      StIdle: en_block_d = blink_d;
      StLoad: level_load_d = 1'b1;
      StServe: begin
        en_block_d  = 1'b1;
        en_paddle_d = 1'b1;
        en_ball_d   = 1'b1;
      end
      StPlay: begin
        en_block_d  = 1'b1;
        en_paddle_d = 1'b1;
        en_ball_d   = 1'b1;
        ball_hold_d = 1'b0;
      end
      StDie: begin
        en_block_d  = 1'b1;
        en_paddle_d = 1'b1;
        en_ball_d   = blink_d;
      end
      StOver: en_block_d = 1'b1;
      StWin: begin
        en_paddle_d = blink_d;
        ball_hold_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      btn_q       <= 1'b0;
      frame_cnt_q <= 7'd0;
      blink_cnt_q <= 7'd0;
      blink_q     <= 1'b0;
      blocks_q    <= NumBlocks;
      lives_q     <= LivesInit;
      level_q     <= 2'd0;
      new_game_q  <= 1'b1;
      en_back     <= 1'b1;
      en_block    <= 1'b0;
      en_paddle   <= 1'b0;
      en_ball     <= 1'b0;
      ball_hold   <= 1'b1;
      level_load  <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_start;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      blocks_q    <= blocks_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      new_game_q  <= new_game_d;
      en_back     <= en_back_d;
      en_block    <= en_block_d;
      en_paddle   <= en_paddle_d;
      en_ball     <= en_ball_d;
      ball_hold   <= ball_hold_d;
      level_load  <= level_load_d;
    end
  end

  assign state = state_q;
  assign lives = lives_q;
  assign level = level_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: directed scenarios then random play, every cycle
// compared against a behavioural model of the game rules.
module tb_game_state_ctrl;

  localparam int LV = 3;
  localparam int NB = 2;
  localparam int SF = 60;
  localparam int DF = 90;
  localparam int BF = 16;

  localparam int IDLE = 0, LOAD = 1, SERVE = 2, PLAY = 3, DIE = 4, OVER = 5, WIN = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0, btn_start = 1'b0, ball_lost = 1'b0, block_hit = 1'b0;
  logic       en_ball, en_block, en_paddle, en_back, ball_hold, level_load;
  logic [2:0] state;
  logic [1:0] lives, level;

  game_state_ctrl #(
    .LIVES(LV), .NUM_BLOCKS(NB), .SERVE_FRAMES(SF), .DEATH_FRAMES(DF), .BLINK_FRAMES(BF)
  ) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .btn_start(btn_start),
    .ball_lost(ball_lost), .block_hit(block_hit), .en_ball(en_ball), .en_block(en_block),
    .en_paddle(en_paddle), .en_back(en_back), .ball_hold(ball_hold),
    .level_load(level_load), .state(state), .lives(lives), .level(level)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [12:0] exp_q[$];

  // Behavioural model of the game rules.
  int m_st, m_lives, m_level, m_blocks, m_frames, m_bcnt;
  bit m_blink, m_newg, m_btn;

  function automatic void model_reset();
    m_st = IDLE; m_lives = LV; m_level = 0; m_blocks = NB; m_frames = 0; m_bcnt = 0;
    m_blink = 0; m_newg = 1; m_btn = 0;
  endfunction

  function automatic void model_step(bit tk, bit st, bit lo, bit hi);
    bit evt;
    int nst;
    evt = st && !m_btn;
    m_btn = st;
    nst = m_st;
    case (m_st)
      IDLE: if (evt) begin nst = LOAD; m_newg = 1; end
      LOAD: begin
        m_blocks = NB;
        if (m_newg) begin m_lives = LV; m_level = 0; m_newg = 0; end
        nst = SERVE;
      end
      SERVE: if (evt || (tk && m_frames + 1 == SF)) nst = PLAY;
      PLAY: begin
        if (hi && m_blocks == 1) nst = WIN;
        else if (lo) nst = DIE;
        if (hi && m_blocks > 0) m_blocks = m_blocks - 1;
      end
      DIE: if (tk && m_frames + 1 == DF) begin
        m_lives = m_lives - 1;
        nst = (m_lives == 0) ? OVER : SERVE;
      end
      OVER: if (evt) begin nst = LOAD; m_newg = 1; end
      WIN: if (evt) begin m_level = (m_level + 1) % 4; nst = LOAD; end
      default: nst = IDLE;
    endcase
    if (nst != m_st) m_frames = 0;
    else if (tk && (m_st == SERVE || m_st == DIE)) m_frames = m_frames + 1;
    if (tk) begin
      if (m_bcnt == BF - 1) begin m_bcnt = 0; m_blink = !m_blink; end
      else m_bcnt = m_bcnt + 1;
    end
    m_st = nst;
  endfunction

  // Packed as {state, lives, level, back, block, paddle, ball, hold, load}.
  function automatic logic [12:0] model_outputs();
    logic blk, pad, bal, hold;
    blk = 0; pad = 0; bal = 0; hold = 1;
    case (m_st)
      IDLE: blk = m_blink;
      SERVE, PLAY: begin blk = 1; pad = 1; bal = 1; end
      DIE: begin blk = 1; pad = 1; bal = m_blink; end
      OVER: blk = 1;
      WIN: pad = m_blink;
      default: ;
    endcase
    if (m_st == PLAY || m_st == WIN) hold = 0;
    return {3'(m_st), 2'(m_lives), 2'(m_level), 1'b1, blk, pad, bal, hold, m_st == LOAD};
  endfunction

  function automatic logic [12:0] dut_outputs();
    return {state, lives, level, en_back, en_block, en_paddle, en_ball, ball_hold, level_load};
  endfunction

  task automatic step(bit tk, bit st, bit lo, bit hi);
    @(negedge clock);
    frame_tick = tk; btn_start = st; ball_lost = lo; block_hit = hi;
    model_step(tk, st, lo, hi);
    exp_q.push_back(model_outputs());
  endtask

  task automatic bound_fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, model state %0d, dut state %0d", name, m_st, state);
  endtask

  // Monitor: every clock edge with a pending expectation is compared.
  initial begin
    logic [12:0] e, g;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = dut_outputs();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got st=%0d lv=%0d lvl=%0d en/hold/load=%b want st=%0d lv=%0d lvl=%0d en/hold/load=%b",
                   $time, g[12:10], g[9:8], g[7:6], g[5:0], e[12:10], e[9:8], e[7:6], e[5:0]);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit b;
    logic [12:0] g;
    model_reset();
    #12;
    g = dut_outputs();
    checks++;
    if (g !== model_outputs()) begin
      errors++;
      $display("FAIL reset: got %b want %b", g, model_outputs());
    end
    @(negedge clock);
    reset = 1'b1;

    // Start with the button held across IDLE, LOAD and SERVE: only one start event.
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    n = 0;
    while (m_st != PLAY && n < 200) begin step(1, 0, 0, 0); n++; end
    if (m_st != PLAY) bound_fail("serve_auto_launch");

    // One hit stays in PLAY, last hit with simultaneous loss wins.
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    // Early launch by button during SERVE.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Lose every life.
    n = 0;
    while (m_st != OVER && n < 2000) begin
      step(1, (m_st == SERVE) && (n % 2 == 1), m_st == PLAY, 0);
      n++;
    end
    if (m_st != OVER) bound_fail("reach_over");
    step(0, 0, 0, 0);

    // New game, then asynchronous reset in the middle of a death count.
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0);
    @(posedge clock);
    #3;
    frame_tick = 0; btn_start = 0; ball_lost = 0; block_hit = 0;
    reset = 1'b0;
    model_reset();
    #1;
    g = dut_outputs();
    checks++;
    if (g !== model_outputs()) begin
      errors++;
      $display("FAIL async_reset: got %b want %b", g, model_outputs());
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Random play.
    b = 0;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 5) == 0) b = !b;
      step($urandom_range(0, 3) == 0, b, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) == 0);
    end

    @(posedge clock);
    #3;
    if (exp_q.size() != 0) bound_fail("scoreboard_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Top-level game sequencer for the Arkanoid display path. It tracks game phase, lives, level and remaining blocks, and drives the per-layer enables that gate the ball, block, paddle and background layers ahead of the priority colour mux. It also issues the level-reload pulse to the block map and the serve-hold flag to the ball logic.

## Interface
Parameters:
- LIVES, 3 — lives at new game; range 1–3.
- NUM_BLOCKS, 40 — blocks per level; range 1–127.
- SERVE_FRAMES, 60 — frames ball is held before auto-launch; range 1–127.
- DEATH_FRAMES, 90 — frames of death animation; range 1–127.
- BLINK_FRAMES, 16 — frames per blink half-period; range 1–127.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- btn_start  in  1  start button level, already synchronised.
- ball_lost  in  1  one-cycle pulse: ball passed paddle.
- block_hit  in  1  one-cycle pulse: one block destroyed.
- en_ball, en_block, en_paddle, en_back  out  1 each  layer enables.
- ball_hold  out  1  ball tracks paddle, not moving.
- level_load  out  1  one-cycle pulse: reload block map.
- state  out  3  current state code.
- lives  out  2  remaining lives.
- level  out  2  current level, wraps 3→0.

## Operation
- States: IDLE=0, LOAD=1, SERVE=2, PLAY=3, DIE=4, OVER=5, WIN=6. Code 7 is unreachable; if entered, go to IDLE.
- Start event (`start_evt`):
  - Rising edge of btn_start, detected with an internal registered copy of btn_start.
  - Holding the button produces one event only.
- Frame counter (7-bit):
  - Cleared on every state entry.
  - Increments on frame_tick in SERVE and DIE only.
- Blink generator:
  - Free-running 7-bit counter advances on frame_tick.
  - On reaching BLINK_FRAMES-1 with a tick: toggle `blink`, clear counter.
- Transitions:
  - IDLE: start_evt → LOAD; set internal new_game flag.
  - LOAD: level_load=1 for exactly this one cycle; blocks_left←NUM_BLOCKS; if new_game then lives←LIVES, level←0, clear new_game. Next state SERVE unconditionally.
  - SERVE: start_evt, or frame counter reaching SERVE_FRAMES on a tick → PLAY.
  - PLAY, in priority order:
    - block_hit with blocks_left=1 → WIN; this takes precedence over a simultaneous ball_lost.
    - Otherwise ball_lost → DIE.
    - block_hit always decrements blocks_left; a hit at blocks_left=0 is ignored, no underflow.
  - DIE: frame counter reaching DEATH_FRAMES on a tick → lives−1. If lives was 1 → OVER (lives=0), else → SERVE.
  - OVER: start_evt → LOAD with new_game set.
  - WIN: start_evt → level+1 (mod 4), → LOAD; lives kept.
- block_hit and ball_lost are ignored outside PLAY.
- Layer enables, listed as back/block/paddle/ball:
  - IDLE: 1 / blink / 0 / 0
  - LOAD: 1 / 0 / 0 / 0
  - SERVE and PLAY: 1 / 1 / 1 / 1
  - DIE: 1 / 1 / 1 / blink
  - OVER: 1 / 1 / 0 / 0
  - WIN: 1 / 0 / blink / 0
- ball_hold=1 in IDLE, LOAD, SERVE, DIE and OVER; 0 in PLAY and WIN.

## Timing
- All outputs are registered and decoded from the next state. An input sampled at edge N changes the outputs at edge N (visible in cycle N+1).
- Reset values:
  - state=IDLE, lives=LIVES, level=0, new_game=1.
  - blink=0, both counters 0, blocks_left=NUM_BLOCKS.
  - en_back=1, en_block=0, en_paddle=0, en_ball=0.
  - ball_hold=1, level_load=0.
- LOAD lasts exactly 1 clock, so level_load is a single-cycle pulse.
- SERVE auto-launch occurs on the SERVE_FRAMES-th frame_tick after entry. DIE ends on the DEATH_FRAMES-th tick.
- A frame_tick coinciding with state entry does not count toward the new state.
- Reset assertion mid-game returns every register to its reset value immediately (asynchronous). Release is used synchronously.

## Test plan
- Reset, then btn_start 0→1 → LOAD for 1 cycle with level_load=1, then SERVE with lives=3, level=0, all enables 1, ball_hold=1.
- In SERVE, apply 60 frame_ticks with no button → PLAY after the 60th tick, ball_hold=0. Repeat with btn_start edge at tick 5 → PLAY immediately.
- In PLAY, apply ball_lost → DIE, with en_ball toggling every 16 ticks. After 90 ticks → SERVE, lives=2. Three losses total → OVER, lives=0, en_paddle=0.
- With NUM_BLOCKS=2 in PLAY: one block_hit → stay in PLAY. Second block_hit in the same cycle as ball_lost → WIN, lives unchanged. btn_start → LOAD then SERVE with level=1 and lives kept.
- Hold btn_start high across IDLE→LOAD→SERVE → exactly one start_evt; SERVE does not launch early.
- Drive reset=0 while in DIE mid-count → outputs immediately take their reset values. After release, state=IDLE and lives=3.
